// File: rtl/lstm_tile_pkg.sv
// Shared definitions for the LSTM tile consumer path: tile geometry, FSM encoding
// and the fixed-point shift/saturate helper used on the output stage.
package lstm_tile_pkg;

  localparam int TILE_DIM = 4;
  // Working width of the saturation helper; must cover the accumulator width.
  localparam int SAT_W    = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } tile_state_e;

  // Arithmetic right shift by frac (rounds toward -inf), then clamp to a signed dw-bit range.
  function automatic logic signed [SAT_W-1:0] shift_sat(
    input logic signed [SAT_W-1:0] a,
    input int                      dw,
    input int                      frac
  );
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] r;
    s  = a >>> frac;
    hi = (SAT_W'(1) <<< (dw - 1)) - SAT_W'(1);
    lo = ~hi;
    if (s > hi)      r = hi;
    else if (s < lo) r = lo;
    else             r = s;
    return r;
  endfunction

endpackage

// File: rtl/tile_dot4.sv
// Combinational 4-lane signed dot product: full-precision products and a
// two-level adder tree, growing one bit per level.
module tile_dot4
  import lstm_tile_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [TILE_DIM*DATA_WIDTH-1:0] w,
  input  logic [TILE_DIM*DATA_WIDTH-1:0] x,
  output logic signed [2*DATA_WIDTH+1:0] dot
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0] prod [TILE_DIM];
  logic signed [PW:0]   sum01;
  logic signed [PW:0]   sum23;

  always_comb begin
    for (int k = 0; k < TILE_DIM; k++) begin
      prod[k] = PW'($signed(w[k*DATA_WIDTH +: DATA_WIDTH])) *
                PW'($signed(x[k*DATA_WIDTH +: DATA_WIDTH]));
    end
    sum01 = (PW+1)'(prod[0]) + (PW+1)'(prod[1]);
    sum23 = (PW+1)'(prod[2]) + (PW+1)'(prod[3]);
    dot   = (PW+2)'(sum01) + (PW+2)'(sum23);
  end

endmodule

// File: rtl/tile_mvm_4x4.sv
// Tile consumer: reads a 4x4 weight tile from the ping-pong bank BRAMs, multiplies by x,
// accumulates per row across a row block and emits saturated Q-format results.
module tile_mvm_4x4
  import lstm_tile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int FRAC_BITS  = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4,
  parameter int BUF_OFFSET = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           tile_done,
  input  logic                           acc_first,
  input  logic                           acc_last,
  input  logic [TILE_DIM*DATA_WIDTH-1:0] x_vec,
  output logic                           wr_buf,
  output logic [ADDR_WIDTH-1:0]          rd_addr,
  output logic                           rd_en,
  input  logic [DATA_WIDTH-1:0]          rd_dout0,
  input  logic [DATA_WIDTH-1:0]          rd_dout1,
  input  logic [DATA_WIDTH-1:0]          rd_dout2,
  input  logic [DATA_WIDTH-1:0]          rd_dout3,
  output logic [TILE_DIM*DATA_WIDTH-1:0] y_vec,
  output logic                           y_valid,
  input  logic                           y_ready,
  output logic                           busy,
  output logic                           overrun_err,
  output tile_state_e                    state_dbg
);

  tile_state_e state, state_nxt;
  logic [1:0]  row, acc_row;
  logic        acc_v;
  logic        rd_buf, cur_last;
  logic [TILE_DIM*DATA_WIDTH-1:0] cur_x, pend_x, y_nxt;
  logic        pend, pend_first, pend_last, pend_buf;
  logic        accept, use_pend, queue_new, queue_ok, drop, clear_acc;
  logic signed [ACC_WIDTH-1:0]    acc     [TILE_DIM];
  logic signed [ACC_WIDTH-1:0]    acc_nxt [TILE_DIM];
  logic signed [2*DATA_WIDTH+1:0] dot;

  tile_dot4 #(.DATA_WIDTH(DATA_WIDTH)) u_dot (
    .w   ({rd_dout3, rd_dout2, rd_dout1, rd_dout0}),
    .x   (cur_x),
    .dot (dot)
  );

  // A queued tile wins over a fresh tile_done in IDLE; that tile_done then takes the freed slot.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    use_pend  = 1'b0;
    case (state)
      ST_IDLE: begin
        use_pend = pend;
        accept   = pend | tile_done;
        if (accept) state_nxt = ST_READ;
      end
      ST_READ:  if (row == 2'd3) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = cur_last ? ST_OUT : ST_IDLE;
      ST_OUT:   if (y_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    queue_new = tile_done & ~(accept & ~use_pend);
    queue_ok  = queue_new & (~pend | use_pend);
    drop      = queue_new & ~queue_ok;
    clear_acc = accept & (use_pend ? pend_first : acc_first);
  end

  // Bank data lags rd_en by one cycle, so row r lands on acc[r] one cycle after its read.
  always_comb begin
    y_nxt = '0;
    for (int i = 0; i < TILE_DIM; i++) begin
      acc_nxt[i] = acc[i];
      if (clear_acc)
        acc_nxt[i] = '0;
      else if (acc_v && (acc_row == 2'(i)))
        acc_nxt[i] = acc[i] + ACC_WIDTH'(dot);
      y_nxt[i*DATA_WIDTH +: DATA_WIDTH] =
        DATA_WIDTH'(shift_sat(SAT_W'(acc_nxt[i]), DATA_WIDTH, FRAC_BITS));
    end
  end

  // Output handshake: y_vec is transferred in a cycle with y_valid & y_ready;
  // y_valid and y_vec hold steady until that cycle, y_valid drops the cycle after.
  assign y_valid   = (state == ST_OUT);
  assign rd_en     = (state == ST_READ);
  assign rd_addr   = rd_en ? ((rd_buf ? ADDR_WIDTH'(BUF_OFFSET) : '0) + ADDR_WIDTH'(row)) : '0;
  assign busy      = (state != ST_IDLE) | pend;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      row         <= '0;
      acc_row     <= '0;
      acc_v       <= 1'b0;
      rd_buf      <= 1'b0;
      wr_buf      <= 1'b0;
      cur_x       <= '0;
      cur_last    <= 1'b0;
      pend        <= 1'b0;
      pend_x      <= '0;
      pend_first  <= 1'b0;
      pend_last   <= 1'b0;
      pend_buf    <= 1'b0;
      overrun_err <= 1'b0;
      y_vec       <= '0;
      for (int i = 0; i < TILE_DIM; i++) acc[i] <= '0;
    end else begin
      state   <= state_nxt;
      acc_v   <= rd_en;
      acc_row <= row;
      if (state == ST_READ) row <= row + 2'd1;
      else if (accept)      row <= '0;
      if (accept) begin
        rd_buf   <= use_pend ? pend_buf  : wr_buf;
        cur_x    <= use_pend ? pend_x    : x_vec;
        cur_last <= use_pend ? pend_last : acc_last;
      end
      if ((accept & ~use_pend) | queue_ok) wr_buf <= ~wr_buf;
      if (queue_ok) begin
        pend       <= 1'b1;
        pend_x     <= x_vec;
        pend_first <= acc_first;
        pend_last  <= acc_last;
        pend_buf   <= wr_buf;
      end else if (use_pend) begin
        pend <= 1'b0;
      end
      if (drop) overrun_err <= 1'b1;
      for (int i = 0; i < TILE_DIM; i++) acc[i] <= acc_nxt[i];
      if ((state == ST_DRAIN) && cur_last) y_vec <= y_nxt;
    end
  end

endmodule
